// File: rtl/fc_pkg.sv
// Shared types and elaboration-time helpers for the fully-connected layer engine.
package fc_pkg;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_SIG  = 2'd1,
        ACT_RELU = 2'd2,
        ACT_RSVD = 2'd3
    } act_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ACT,
        ST_OUT
    } state_t;

    function automatic int unsigned fc_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) r++;
        return r;
    endfunction

    // Sigmoid entry for a DW-bit two's-complement code, computed with a
    // fixed-point exp series so the table needs no real arithmetic.
    function automatic int sig_entry(input int dw, input int frac, input int code);
        longint one, term, e, num, den, y;
        int     x, ax;
        one  = longint'(1) << 40;
        x    = (code >= (1 << (dw - 1))) ? code - (1 << dw) : code;
        ax   = (x < 0) ? -x : x;
        term = one;
        e    = one;
        for (int unsigned k = 1; k < 64; k++) begin
            term = (term * ax) / (longint'(k) << frac);
            e    = e + term;
        end
        den = 2 * (e + one);
        num = (x >= 0) ? ((longint'(2) << frac) * e) : ((longint'(2) << frac) * one);
        y   = (num + e + one) / den;
        if (y > (longint'(1) << (dw - 1)) - 1) y = (longint'(1) << (dw - 1)) - 1;
        return int'(y);
    endfunction

endpackage

// File: rtl/act_unit.sv
// Combinational activation: pass-through, ReLU, or table-based sigmoid.
module act_unit
    import fc_pkg::*;
#(
    parameter int DW   = 7,
    parameter int FRAC = 4
) (
    input  act_t                 i_sel,
    input  logic signed [DW-1:0] i_x,
    output logic signed [DW-1:0] o_y
);

    logic signed [DW-1:0] w_tab [2**DW];

    for (genvar g = 0; g < 2**DW; g++) begin : g_sig
        localparam int V = sig_entry(DW, FRAC, g);
        assign w_tab[g] = DW'(V);
    end

    always_comb begin
        o_y = i_x;
        case (i_sel)
            ACT_SIG:  o_y = w_tab[$unsigned(i_x)];
            ACT_RELU: if (i_x[DW-1]) o_y = '0;
            default:  ;
        endcase
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer sequencer: per neuron, stream N_IN x/w pairs, MAC,
// round, saturate, activate, and hand the result off over valid/ready.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int DW    = 7,
    parameter int FRAC  = 4,
    parameter int N_IN  = 400,
    parameter int N_OUT = 25,
    parameter int XAW   = 9,
    parameter int WAW   = 14,
    parameter int OAW   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            act_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  x_rd,
    output logic [XAW-1:0]        x_addr,
    input  logic signed [DW-1:0]  x_data,
    output logic                  w_rd,
    output logic [WAW-1:0]        w_addr,
    input  logic signed [DW-1:0]  w_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic signed [DW-1:0]  y_data,
    output logic [OAW-1:0]        y_idx
);

    localparam int unsigned CW = fc_clog2(N_IN + 1);
    localparam int unsigned AW = 2 * DW + fc_clog2(N_IN);
    localparam logic signed [AW-1:0] RND  = AW'(2**(FRAC - 1));
    localparam logic signed [AW-1:0] SMAX = AW'(2**(DW - 1) - 1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(2**(DW - 1)));

    state_t                r_state, w_next;
    act_t                  r_act;
    logic [CW-1:0]         r_cnt;
    logic [OAW-1:0]        r_neuron;
    logic [WAW-1:0]        r_wnext;
    logic                  r_rd, r_rdv, r_done;
    logic [XAW-1:0]        r_xaddr;
    logic [WAW-1:0]        r_waddr;
    logic signed [AW-1:0]  r_acc;
    logic signed [DW-1:0]  r_ydata;
    logic [OAW-1:0]        r_yidx;

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_rnd;
    logic signed [DW-1:0]   w_sat, w_act;
    logic                   w_fetch_end, w_last_neuron, w_enter_fetch;

    assign w_prod        = (2*DW)'(x_data) * (2*DW)'(w_data);
    assign w_rnd         = (r_acc + RND) >>> FRAC;
    assign w_fetch_end   = (r_cnt == CW'(N_IN));
    assign w_last_neuron = (r_neuron == OAW'(N_OUT - 1));
    assign w_enter_fetch = (w_next == ST_FETCH) && (r_state != ST_FETCH);

    always_comb begin
        if (w_rnd > SMAX)      w_sat = SMAX[DW-1:0];
        else if (w_rnd < SMIN) w_sat = SMIN[DW-1:0];
        else                   w_sat = w_rnd[DW-1:0];
    end

    act_unit #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_act (
        .i_sel (r_act),
        .i_x   (w_sat),
        .o_y   (w_act)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_FETCH;
            ST_FETCH: if (w_fetch_end) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_ACT;
            ST_ACT:   w_next = ST_OUT;
            ST_OUT:   if (y_ready) w_next = w_last_neuron ? ST_IDLE : ST_FETCH;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The first FETCH cycle only clears state; addresses are registered, so
    // the N_IN strobes land one cycle later and read data one cycle after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act    <= ACT_NONE;
            r_cnt    <= '0;
            r_neuron <= '0;
            r_wnext  <= '0;
            r_rd     <= 1'b0;
            r_rdv    <= 1'b0;
            r_done   <= 1'b0;
            r_xaddr  <= '0;
            r_waddr  <= '0;
            r_acc    <= '0;
            r_ydata  <= '0;
            r_yidx   <= '0;
        end else begin
            r_done <= 1'b0;
            r_rdv  <= r_rd;
            if (w_enter_fetch) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_rdv) begin
                r_acc <= r_acc + AW'(w_prod);
            end
            case (r_state)
                ST_IDLE: begin
                    r_neuron <= '0;
                    r_wnext  <= '0;
                    if (start) r_act <= act_t'(act_sel);
                end
                ST_FETCH: begin
                    if (w_fetch_end) begin
                        r_rd <= 1'b0;
                    end else begin
                        r_rd    <= 1'b1;
                        r_xaddr <= XAW'(r_cnt);
                        r_waddr <= r_wnext;
                        r_wnext <= r_wnext + WAW'(1);
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                ST_ACT: begin
                    r_ydata <= w_act;
                    r_yidx  <= r_neuron;
                end
                ST_OUT: begin
                    if (y_ready) begin
                        if (w_last_neuron) r_done <= 1'b1;
                        else               r_neuron <= r_neuron + OAW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign x_rd    = r_rd;
    assign w_rd    = r_rd;
    assign x_addr  = r_xaddr;
    assign w_addr  = r_waddr;
    assign y_valid = (r_state == ST_OUT);
    assign y_data  = r_ydata;
    assign y_idx   = r_yidx;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine with small synchronous x/w memory models.
module tb_fc_layer_engine;

    localparam int DW    = 7;
    localparam int FRAC  = 4;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int XAW   = 4;
    localparam int WAW   = 4;
    localparam int OAW   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [1:0]           act_sel = 2'd0;
    logic                 y_ready = 1'b0;
    logic                 busy, done, x_rd, w_rd, y_valid;
    logic [XAW-1:0]       x_addr;
    logic [WAW-1:0]       w_addr;
    logic signed [DW-1:0] x_data, w_data, y_data;
    logic [OAW-1:0]       y_idx;

    logic signed [DW-1:0] x_mem [16];
    logic signed [DW-1:0] w_mem [16];

    typedef struct {
        int data;
        int idx;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_hs = 0;
    int   n_done = 0;

    fc_layer_engine #(
        .DW    (DW),
        .FRAC  (FRAC),
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .XAW   (XAW),
        .WAW   (WAW),
        .OAW   (OAW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .act_sel (act_sel),
        .busy    (busy),
        .done    (done),
        .x_rd    (x_rd),
        .x_addr  (x_addr),
        .x_data  (x_data),
        .w_rd    (w_rd),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data),
        .y_idx   (y_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (x_rd) x_data <= x_mem[x_addr];
        if (w_rd) w_data <= w_mem[w_addr];
    end

    task automatic check_eq(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic int model(input int n, input logic [1:0] sel);
        int  acc;
        int  r;
        real s;
        acc = 0;
        for (int i = 0; i < N_IN; i++) acc += int'(x_mem[i]) * int'(w_mem[n * N_IN + i]);
        r = (acc + (1 << (FRAC - 1))) >>> FRAC;
        if (r > 63)  r = 63;
        if (r < -64) r = -64;
        case (sel)
            2'd1: begin
                s = 16.0 / (1.0 + $exp(-r / 16.0));
                r = int'($floor(s + 0.5));
                if (r > 63) r = 63;
            end
            2'd2: if (r < 0) r = 0;
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (y_valid && y_ready) begin
                n_hs++;
                check_eq("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    check_eq("y_data", int'(y_data), m_e.data);
                    check_eq("y_idx", int'(y_idx), m_e.idx);
                end
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            x_mem[i] = DW'($urandom_range(0, 127));
            w_mem[i] = DW'($urandom_range(0, 127));
        end
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        @(posedge clk); #1;
        start = 1'b1;
        act_sel = sel;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [1:0] sel, input bit spam, input bit chk_lat);
        int hs0, d0, k;
        bit seen;
        hs0 = n_hs;
        d0  = n_done;
        for (int n = 0; n < N_OUT; n++) sb.push_back('{model(n, sel), n});
        pulse_start(sel);
        if (chk_lat) begin
            check_eq("busy_after_start", int'(busy), 1);
            k = 0;
            seen = 1'b0;
            while (!y_valid && k < 40) begin
                @(posedge clk); #1;
                k++;
                if (x_rd && !seen) begin
                    seen = 1'b1;
                    check_eq("first_waddr", int'(w_addr), 0);
                    check_eq("first_xaddr", int'(x_addr), 0);
                end
            end
            check_eq("latency", k, N_IN + 3);
        end
        k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #1;
            start = spam && busy && (k % 3 == 1);
            k++;
        end
        start = 1'b0;
        check_eq("run_timeout", int'(busy), 0);
        repeat (2) @(negedge clk);
        check_eq("handshakes", n_hs - hs0, N_OUT);
        check_eq("done_pulses", n_done - d0, 1);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    task automatic bp_test();
        int hs0, d0, k;
        fill_random();
        hs0 = n_hs;
        d0  = n_done;
        y_ready = 1'b0;
        for (int n = 0; n < N_OUT; n++) sb.push_back('{model(n, 2'd2), n});
        pulse_start(2'd2);
        k = 0;
        while (!y_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("bp_valid_seen", int'(y_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid_hold", int'(y_valid), 1);
            check_eq("bp_data_hold", int'(y_data), sb[0].data);
            check_eq("bp_idx_hold", int'(y_idx), 0);
            check_eq("bp_xrd_low", int'(x_rd), 0);
            check_eq("bp_waddr_hold", int'(w_addr), N_IN - 1);
        end
        @(posedge clk); #1;
        y_ready = 1'b1;
        k = 0;
        while (!x_rd && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("bp_n1_waddr", int'(w_addr), N_IN);
        check_eq("bp_n1_xaddr", int'(x_addr), 0);
        k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (2) @(negedge clk);
        check_eq("bp_handshakes", n_hs - hs0, N_OUT);
        check_eq("bp_done", n_done - d0, 1);
        check_eq("bp_sb_drained", sb.size(), 0);
    endtask

    task automatic rst_test();
        int hs0, d0, k;
        fill_random();
        hs0 = n_hs;
        d0  = n_done;
        y_ready = 1'b1;
        sb.push_back('{model(0, 2'd0), 0});
        pulse_start(2'd0);
        k = 0;
        while (n_hs == hs0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        k = 0;
        while (!x_rd && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        check_eq("mid_fetch_xrd", int'(x_rd), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst2_busy", int'(busy), 0);
        check_eq("rst2_xrd", int'(x_rd), 0);
        check_eq("rst2_wrd", int'(w_rd), 0);
        check_eq("rst2_valid", int'(y_valid), 0);
        check_eq("rst2_xaddr", int'(x_addr), 0);
        check_eq("rst2_waddr", int'(w_addr), 0);
        check_eq("rst2_ydata", int'(y_data), 0);
        check_eq("rst2_yidx", int'(y_idx), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("rst_no_partial", n_hs - hs0, 1);
        check_eq("rst_no_done", n_done - d0, 0);
        check_eq("rst_sb_drained", sb.size(), 0);
        run(2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        y_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_xrd", int'(x_rd), 0);
        check_eq("rst_wrd", int'(w_rd), 0);
        check_eq("rst_valid", int'(y_valid), 0);
        check_eq("rst_xaddr", int'(x_addr), 0);
        check_eq("rst_waddr", int'(w_addr), 0);
        check_eq("rst_ydata", int'(y_data), 0);
        check_eq("rst_yidx", int'(y_idx), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            x_mem[i] = 7'sd16;
            w_mem[i] = 7'sd16;
        end
        run(2'd0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) w_mem[i] = -7'sd16;
        run(2'd0, 1'b1, 1'b0);
        run(2'd2, 1'b0, 1'b0);
        run(2'd1, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            x_mem[i] = '0;
            w_mem[i] = '0;
        end
        x_mem[0]    = 7'sd1;
        w_mem[0]    = 7'sd8;
        w_mem[N_IN] = 7'sd7;
        run(2'd0, 1'b0, 1'b0);
        x_mem[0] = '0;
        run(2'd1, 1'b0, 1'b0);
        run(2'd3, 1'b0, 1'b0);

        repeat (3) begin
            fill_random();
            run(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        bp_test();
        rst_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
- Parametrised fully-connected layer sequencer: for each of N_OUT neurons, streams N_IN inputs and weights from synchronous ROM/RAMs, forms a signed MAC, rounds and saturates the result, applies a selectable activation, and emits one result per neuron over a valid/ready handshake.
- Two or more instances chain to build multi-layer networks. A downstream buffer captures y_data by y_idx and becomes the next instance's input memory.

Parameters:
- DW, 7, signed data width of inputs, weights and outputs (two's complement, Q(DW-1-FRAC).FRAC).
- FRAC, 4, fractional bits of all data.
- N_IN, 400, inputs per neuron (≥1).
- N_OUT, 25, neurons per layer (≥1).
- XAW, 9, input memory address width (2^XAW ≥ N_IN).
- WAW, 14, weight memory address width (2^WAW ≥ N_IN*N_OUT).
- OAW, 5, output index width (2^OAW ≥ N_OUT).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  start pulse; sampled only in IDLE
- act_sel  in  2  activation: 0 none, 1 sigmoid, 2 ReLU, 3 reserved (acts as none); latched at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last neuron handshake
- x_rd  out  1  input memory read strobe
- x_addr  out  XAW  input memory address
- x_data  in  DW  input memory data, 1-cycle read latency
- w_rd  out  1  weight memory read strobe
- w_addr  out  WAW  weight address = neuron*N_IN + i
- w_data  in  DW  weight data, 1-cycle read latency
- y_valid  out  1  result valid
- y_ready  in  1  downstream accept
- y_data  out  DW  activated neuron result
- y_idx  out  OAW  neuron index of y_data

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. busy, done, x_rd, w_rd, y_valid = 0. x_addr, w_addr, y_data, y_idx, accumulator and counters = 0. Applies from any state, including mid-FETCH or mid-OUT. No partial output is emitted afterwards.
- FSM states: IDLE, FETCH, DRAIN, ACT, OUT.
- IDLE:
  - start=1 latches act_sel and moves to FETCH.
  - neuron counter = 0; w_addr base = 0.
  - start in any other state is ignored.
- FETCH (N_IN cycles):
  - x_rd = w_rd = 1; x_addr = 0..N_IN-1; w_addr increments by 1 every cycle and continues across neurons without reset.
  - A read-valid flag delayed by 1 cycle gates accumulation.
  - Accumulator cleared on FETCH entry.
  - After address N_IN-1 is issued, go to DRAIN.
- DRAIN (1 cycle): strobes low; last product accumulated; go to ACT.
- ACT (1 cycle): register y_data = act(sat(round(acc))); y_idx = neuron; go to OUT.
- OUT:
  - y_valid = 1; y_data and y_idx held stable until y_ready=1.
  - On handshake: if neuron = N_OUT-1, pulse done, drop busy and go to IDLE. Otherwise increment neuron and go to FETCH.
  - y_ready while y_valid=0 has no effect.
- Latency: y_valid first rises N_IN+3 clk edges after the start-accepting edge. Per-neuron throughput is N_IN+3 cycles plus handshake stall.
- Arithmetic:
  - Product is 2*DW bits signed.
  - Accumulator is 2*DW+clog2(N_IN) bits and never wraps.
  - Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- Activation:
  - none: passes the saturated value.
  - ReLU: negative values → 0.
  - sigmoid: y = round(2^FRAC / (1+e^(-x/2^FRAC))), clamped to max positive.

Decomposition:
- Package fc_pkg: act_sel encodings (ACT_NONE/SIG/RELU), FSM state enum, clog2 helper, sigmoid table generation function (elaboration-time, 2^DW entries).
- Sub-module act_unit: combinational activation over DW/FRAC, table indexed by the input's two's-complement code.

Test Plan:
- DW=7, FRAC=4, N_IN=4, N_OUT=2, act none, all x=16, all w=16 → acc 1024, round 64, y_data=63 (saturated), y_idx 0 then 1, done pulse once, y_valid first at edge 7.
- Same config, all w=-16, act none/ReLU/sigmoid in three runs → y_data -64 / 0 / 0.
- Rounding with N_IN=1, x=1: w=8 → y_data 1; w=7 → y_data 0; act sigmoid, x=0 (w=0) → y_data 8.
- Backpressure: hold y_ready=0 for 5 cycles in OUT → y_valid, y_data, y_idx stable; x_rd=0; no w_addr advance; neuron 1 w_addr starts at 4.
- Assert rst mid-FETCH of neuron 1 → next cycle all outputs 0, IDLE; new start reruns from neuron 0, w_addr 0, correct results.
- start pulsed while busy, and y_ready held high in IDLE → no effect; exactly N_OUT handshakes and one done per accepted start.
